// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU register port, source read port and
// destination write port. The master modport is the DMA engine itself.
interface oam_dma_if #(
  parameter int p_ADDR_BITS = 16,
  parameter int p_DATA_BITS = 8
);
  logic [p_ADDR_BITS-1:0] reg_addr;
  logic                   reg_wen;
  logic [p_DATA_BITS-1:0] reg_wdata;
  logic [p_DATA_BITS-1:0] reg_rdata;
  logic [p_ADDR_BITS-1:0] src_addr;
  logic                   src_ren;
  logic [p_DATA_BITS-1:0] src_q;
  logic [p_ADDR_BITS-1:0] dst_addr;
  logic                   dst_wen;
  logic [p_DATA_BITS-1:0] dst_data;
  logic                   busy;

  // Handshake: reg_wen, src_ren and dst_wen are single-cycle strobes that
  // complete in the cycle they are high; there is no ready/backpressure.
  // src_q answers a src_ren exactly one cycle later.
  modport master (
    input  reg_addr, reg_wen, reg_wdata, src_q,
    output reg_rdata, src_addr, src_ren, dst_addr, dst_wen, dst_data, busy
  );

  modport slave (
    output reg_addr, reg_wen, reg_wdata, src_q,
    input  reg_rdata, src_addr, src_ren, dst_addr, dst_wen, dst_data, busy
  );
endinterface

// File: rtl/oam_dma.sv
// Game Boy OAM DMA: copies p_XFER_LEN bytes from {page, 8'h00} to p_DST_BASE,
// one read per cycle with the matching write one cycle later.
module oam_dma #(
  parameter int p_ADDR_BITS = 16,
  parameter int p_DATA_BITS = 8,
  parameter int p_XFER_LEN  = 160,
  parameter int p_DST_BASE  = 'hFE00,
  parameter int p_REG_ADDR  = 'hFF46
) (
  input  logic       clk,
  input  logic       rst,
  oam_dma_if.master  bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0]             LAST_IDX = 8'(p_XFER_LEN - 1);
  localparam logic [p_ADDR_BITS-1:0] DST_BASE = p_ADDR_BITS'(p_DST_BASE);
  localparam logic [p_ADDR_BITS-1:0] REG_ADDR = p_ADDR_BITS'(p_REG_ADDR);

  state_t                 state_q, state_d;
  logic [7:0]             idx_q, idx_d;
  logic [p_DATA_BITS-1:0] page_q, page_d;
  logic                   src_ren_q, src_ren_d;
  logic [p_ADDR_BITS-1:0] src_addr_q, src_addr_d;
  logic                   dst_wen_q, dst_wen_d;
  logic [p_ADDR_BITS-1:0] dst_addr_q, dst_addr_d;
  logic                   busy_q, busy_d;
  logic                   trig;

  assign trig = bus.reg_wen && (bus.reg_addr == REG_ADDR);

  // idx_q always names the read currently on src_addr; the write stage is
  // loaded from it at the following edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    page_d     = page_q;
    src_ren_d  = 1'b0;
    src_addr_d = src_addr_q;
    dst_wen_d  = 1'b0;
    dst_addr_d = dst_addr_q;
    busy_d     = 1'b0;

    case (state_q)
      IDLE: ;
      RUN: begin
        dst_wen_d  = 1'b1;
        dst_addr_d = DST_BASE + p_ADDR_BITS'(idx_q);
        busy_d     = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d      = idx_q + 8'd1;
          src_ren_d  = 1'b1;
          src_addr_d = p_ADDR_BITS'({page_q, idx_q + 8'd1});
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A retrigger restarts the read stage but leaves the write stage loaded
    // above, so the in-flight byte still lands at its old address.
    if (trig) begin
      state_d    = RUN;
      page_d     = bus.reg_wdata;
      idx_d      = 8'd0;
      src_ren_d  = 1'b1;
      src_addr_d = p_ADDR_BITS'({bus.reg_wdata, 8'h00});
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      page_q     <= '0;
      src_ren_q  <= 1'b0;
      src_addr_q <= '0;
      dst_wen_q  <= 1'b0;
      dst_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      page_q     <= page_d;
      src_ren_q  <= src_ren_d;
      src_addr_q <= src_addr_d;
      dst_wen_q  <= dst_wen_d;
      dst_addr_q <= dst_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.reg_rdata = page_q;
  assign bus.src_ren   = src_ren_q;
  assign bus.src_addr  = src_addr_q;
  assign bus.dst_wen   = dst_wen_q;
  assign bus.dst_addr  = dst_addr_q;
  assign bus.dst_data  = bus.src_q;
  assign bus.busy      = busy_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: scoreboard of expected reads/writes per cycle built from
// the transfer rules, plus small-parameter instances for the edge cases.
module tb_oam_dma;
  localparam int         L    = 160;
  localparam logic [15:0] BASE = 16'hFE00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  oam_dma_if #(.p_ADDR_BITS(16), .p_DATA_BITS(8)) bus ();
  oam_dma_if #(.p_ADDR_BITS(16), .p_DATA_BITS(8)) b1 ();
  oam_dma_if #(.p_ADDR_BITS(16), .p_DATA_BITS(8)) b2 ();
  logic [1:0] st0, st1, st2;

  oam_dma #(.p_XFER_LEN(L)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .state_dbg(st0));
  oam_dma #(.p_XFER_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.master), .state_dbg(st1));
  oam_dma #(.p_XFER_LEN(2), .p_DST_BASE('hFFFF)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.master), .state_dbg(st2));

  // ---------------- memory models ----------------
  logic [7:0] src_mem [65536];
  logic [7:0] dst_mem [65536];

  always @(posedge clk) begin
    if (bus.src_ren) bus.src_q <= src_mem[bus.src_addr];
    if (bus.dst_wen) dst_mem[bus.dst_addr] <= bus.dst_data;
    if (b1.src_ren) b1.src_q <= b1.src_addr[7:0] ^ 8'h3C;
    if (b2.src_ren) b2.src_q <= b2.src_addr[7:0] ^ 8'h3C;
  end

  // ---------------- scoreboard ----------------
  logic [55:0] exp_q[$];  // {cycle, dst_addr, data}
  logic [47:0] rd_q[$];   // {cycle, src_addr}
  int n_checks = 0;
  int n_fail   = 0;
  int bstart   = 1;
  int bend     = 0;
  logic [7:0] rdata_exp = 8'h00;
  bit chk_en  = 1'b0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    if (n_fail <= 40) $display("FAIL %s: got 'h%0h expected nothing", name, act);
  endtask

  // Drop expected traffic that a retrigger or reset cancels.
  task automatic trim(input int rd_lim, input int wr_lim);
    logic [47:0] r;
    logic [55:0] w;
    while (rd_q.size() > 0) begin
      r = rd_q[$];
      if (int'(r[47:16]) > rd_lim) void'(rd_q.pop_back()); else break;
    end
    while (exp_q.size() > 0) begin
      w = exp_q[$];
      if (int'(w[55:24]) > wr_lim) void'(exp_q.pop_back()); else break;
    end
  endtask

  logic [47:0] e_rd;
  logic [55:0] e_wr;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(cyc >= bstart && cyc <= bend));
      check("reg_rdata", 64'(bus.reg_rdata), 64'(rdata_exp));
      if (bus.busy) busy_cnt++;
      if (bus.src_ren) begin
        if (rd_q.size() == 0) flag("read_unexpected", 64'(bus.src_addr));
        else begin
          e_rd = rd_q.pop_front();
          check("read_cyc_addr", {16'h0, 32'(cyc), bus.src_addr}, 64'(e_rd));
        end
      end
      if (bus.dst_wen) begin
        if (exp_q.size() == 0) flag("write_unexpected", 64'(bus.dst_addr));
        else begin
          e_wr = exp_q.pop_front();
          check("write_cyc_addr_data", {8'h0, 32'(cyc), bus.dst_addr, bus.dst_data}, 64'(e_wr));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [7:0] pg);
    int t;
    t = cyc;
    bus.reg_addr  = 16'hFF46;
    bus.reg_wdata = pg;
    bus.reg_wen   = 1'b1;
    trim(t, t + 1);
    for (int i = 0; i < L; i++) begin
      rd_q.push_back({32'(t + 1 + i), pg, 8'(i)});
      exp_q.push_back({32'(t + 2 + i), BASE + 16'(i), src_mem[{pg, 8'(i)}]});
    end
    if (t + 1 > bend) bstart = t + 1;
    bend = t + L + 1;
    @(posedge clk);
    #1;
    bus.reg_wen = 1'b0;
    rdata_exp   = pg;
  endtask

  task automatic write_other(input logic [15:0] a, input logic [7:0] d);
    bus.reg_addr  = (a == 16'hFF46) ? 16'hFF47 : a;
    bus.reg_wdata = d;
    bus.reg_wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_wen = 1'b0;
  endtask

  task automatic do_reset();
    int r;
    r = cyc;
    rst = 1'b1;
    trim(r, r);
    if (bend > r) bend = r;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdata_exp = 8'h00;
  endtask

  task automatic check_oam(input string name, input logic [7:0] pg, input int lo, input int hi);
    int errs;
    errs = 0;
    for (int i = lo; i <= hi; i++)
      if (dst_mem[BASE + 16'(i)] !== src_mem[{pg, 8'(i)}]) errs++;
    check(name, 64'(errs), 64'd0);
  endtask

  // ---------------- edge-parameter recorders ----------------
  bit edge_en = 1'b0;
  int b1_rd_n = 0, b1_wr_n = 0, b1_busy_n = 0, b1_rd_cyc = 0, b1_wr_cyc = 0, b2_wr_n = 0;
  logic [15:0] b1_rd_addr, b1_wr_addr;
  logic [7:0]  b1_wr_data;
  logic [15:0] b2_wr_addr [4];
  logic [7:0]  b2_wr_data [4];

  always @(negedge clk) begin
    if (edge_en) begin
      if (b1.src_ren) begin b1_rd_n++; b1_rd_addr = b1.src_addr; b1_rd_cyc = cyc; end
      if (b1.dst_wen) begin
        b1_wr_n++; b1_wr_addr = b1.dst_addr; b1_wr_data = b1.dst_data; b1_wr_cyc = cyc;
      end
      if (b1.busy) b1_busy_n++;
      if (b2.dst_wen) begin
        if (b2_wr_n < 4) begin
          b2_wr_addr[b2_wr_n] = b2.dst_addr;
          b2_wr_data[b2_wr_n] = b2.dst_data;
        end
        b2_wr_n++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    logic [7:0] pg;
    bus.reg_addr = '0; bus.reg_wen = 1'b0; bus.reg_wdata = '0;
    b1.reg_addr  = '0; b1.reg_wen  = 1'b0; b1.reg_wdata  = '0;
    b2.reg_addr  = '0; b2.reg_wen  = 1'b0; b2.reg_wdata  = '0;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) src_mem[{8'hC0, 8'(i)}] = 8'(i) ^ 8'h5A;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_src_ren", 64'(bus.src_ren), 64'd0);
    check("rst_dst_wen", 64'(bus.dst_wen), 64'd0);
    check("rst_src_addr", 64'(bus.src_addr), 64'd0);
    check("rst_dst_addr", 64'(bus.dst_addr), 64'd0);
    check("rst_reg_rdata", 64'(bus.reg_rdata), 64'd0);
    chk_en = 1'b1;

    // basic copy
    busy_cnt = 0;
    trigger(8'hC0);
    wait_cycles(170);
    check("basic_busy_cycles", 64'(busy_cnt), 64'(L + 1));
    check("basic_first_byte", 64'(dst_mem[16'hFE00]), 64'h5A);
    check_oam("basic_oam", 8'hC0, 0, L - 1);

    // register readback and address decode
    trigger(8'h80);
    check("readback_80", 64'(bus.reg_rdata), 64'h80);
    wait_cycles(170);
    write_other(16'hFF47, 8'h12);
    wait_cycles(3);
    check("decode_rdata", 64'(bus.reg_rdata), 64'h80);
    check("decode_no_busy", 64'(bus.busy), 64'd0);

    // retrigger at idx 50
    trigger(8'hC0);
    wait_cycles(50);
    trigger(8'hD0);
    wait_cycles(170);
    check_oam("retrig_oam", 8'hD0, 0, L - 1);

    // reset at idx 20
    trigger(8'hA0);
    wait_cycles(20);
    do_reset();
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_src_ren", 64'(bus.src_ren), 64'd0);
    check("midrst_dst_wen", 64'(bus.dst_wen), 64'd0);
    check("midrst_rdata", 64'(bus.reg_rdata), 64'd0);
    wait_cycles(5);
    check_oam("midrst_head", 8'hA0, 0, 19);
    check_oam("midrst_untouched", 8'hD0, 21, L - 1);
    trigger(8'hC0);
    wait_cycles(170);
    check_oam("post_rst_copy", 8'hC0, 0, L - 1);

    // randomized retriggers and foreign register writes
    for (int k = 0; k < 6; k++) begin
      pg = 8'($urandom);
      trigger(pg);
      wait_cycles($urandom_range(0, 60));
      write_other(16'($urandom), 8'($urandom));
      wait_cycles($urandom_range(0, 150));
    end
    wait_cycles(170);

    // edge parameters: length 1, and destination wrap
    edge_en = 1'b1;
    t = cyc;
    b1.reg_addr = 16'hFF46; b1.reg_wdata = 8'hFF; b1.reg_wen = 1'b1;
    b2.reg_addr = 16'hFF46; b2.reg_wdata = 8'h30; b2.reg_wen = 1'b1;
    @(posedge clk);
    #1;
    b1.reg_wen = 1'b0;
    b2.reg_wen = 1'b0;
    wait_cycles(8);
    edge_en = 1'b0;
    check("len1_reads", 64'(b1_rd_n), 64'd1);
    check("len1_read_addr", 64'(b1_rd_addr), 64'hFF00);
    check("len1_read_cyc", 64'(b1_rd_cyc), 64'(t + 1));
    check("len1_writes", 64'(b1_wr_n), 64'd1);
    check("len1_write_addr", 64'(b1_wr_addr), 64'hFE00);
    check("len1_write_data", 64'(b1_wr_data), 64'h3C);
    check("len1_write_cyc", 64'(b1_wr_cyc), 64'(t + 2));
    check("len1_busy_cycles", 64'(b1_busy_n), 64'd2);
    check("wrap_writes", 64'(b2_wr_n), 64'd2);
    check("wrap_addr0", 64'(b2_wr_addr[0]), 64'hFFFF);
    check("wrap_addr1", 64'(b2_wr_addr[1]), 64'h0000);
    check("wrap_data0", 64'(b2_wr_data[0]), 64'h3C);
    check("wrap_data1", 64'(b2_wr_data[1]), 64'h3D);

    check("reads_outstanding", 64'(rd_q.size()), 64'd0);
    check("writes_outstanding", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
